re_order_buffer_p: RTL and testbench

RE_ORDER_BUFFER_P -- requirements
Module: re_order_buffer_p

---
 rtl/re_order_buffer_p.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_re_order_buffer_p.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/re_order_buffer_p.sv
// Re-order buffer: in-order allocation, out-of-order writeback, in-order commit of up to two
// register writes per cycle, a blocking store handshake and mispredict flush.
module re_order_buffer_p #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [1:0]        alloc_class,
    input  logic [1:0]        alloc_size,
    input  logic [4:0]        alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic [TAG_W-1:0]  rs1_tag,
    output logic              rs1_ready,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [TAG_W-1:0]  rs2_tag,
    output logic              rs2_ready,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb0_redirect,
    input  logic [DATA_W-1:0] wb0_pc,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic [DATA_W-1:0] wb1_addr,
    output logic              bc0_valid,
    output logic [TAG_W-1:0]  bc0_tag,
    output logic [DATA_W-1:0] bc0_data,
    output logic              bc1_valid,
    output logic [TAG_W-1:0]  bc1_tag,
    output logic [DATA_W-1:0] bc1_data,
    output logic              cm0_valid,
    output logic [4:0]        cm0_rd,
    output logic [DATA_W-1:0] cm0_data,
    output logic [TAG_W-1:0]  cm0_tag,
    output logic              cm1_valid,
    output logic [4:0]        cm1_rd,
    output logic [DATA_W-1:0] cm1_data,
    output logic [TAG_W-1:0]  cm1_tag,
    output logic              st_req_valid,
    output logic [DATA_W-1:0] st_req_addr,
    output logic [DATA_W-1:0] st_req_data,
    output logic [1:0]        st_req_size,
    input  logic              st_done,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              flush,
    output logic [TAG_W:0]    occupancy
);

    localparam logic [1:0] ClsReg   = 2'd0;
    localparam logic [1:0] ClsStore = 2'd1;

    typedef enum logic [0:0] {StIdle, StStWait} state_e;
    state_e state_q, state_d;

    logic [TAG_W:0]    head_q, head_d, tail_q, tail_d, ret_cnt;
    logic [TAG_W-1:0]  head_idx, head1_idx, tail_idx;
    logic [DEPTH-1:0]  busy_q, busy_d, ready_q, ready_d;
    logic [1:0]        cls_q   [DEPTH];
    logic [1:0]        cls_d   [DEPTH];
    logic [1:0]        size_q  [DEPTH];
    logic [1:0]        size_d  [DEPTH];
    logic [4:0]        rd_q    [DEPTH];
    logic [4:0]        rd_d    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [DATA_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] addr_d  [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] pc_d    [DEPTH];
    logic              redir_q [DEPTH];
    logic              redir_d [DEPTH];

    logic full, head_ok, pair_ok, alloc_fire;
    logic ret_one, ret_two, st_start, st_finish, flush_now;

    logic              bc0_valid_q, bc0_valid_d, bc1_valid_q, bc1_valid_d;
    logic [TAG_W-1:0]  bc0_tag_q, bc0_tag_d, bc1_tag_q, bc1_tag_d;
    logic [DATA_W-1:0] bc0_data_q, bc0_data_d, bc1_data_q, bc1_data_d;
    logic              cm0_valid_q, cm0_valid_d, cm1_valid_q, cm1_valid_d;
    logic [4:0]        cm0_rd_q, cm0_rd_d, cm1_rd_q, cm1_rd_d;
    logic [DATA_W-1:0] cm0_data_q, cm0_data_d, cm1_data_q, cm1_data_d;
    logic [TAG_W-1:0]  cm0_tag_q, cm0_tag_d, cm1_tag_q, cm1_tag_d;
    logic              redirect_valid_q, redirect_valid_d, flush_q, flush_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    assign head_idx    = head_q[TAG_W-1:0];
    assign head1_idx   = head_idx + TAG_W'(1);
    assign tail_idx    = tail_q[TAG_W-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign occupancy   = tail_q - head_q;

    assign head_ok    = busy_q[head_idx] && ready_q[head_idx];
    assign pair_ok    = busy_q[head1_idx] && ready_q[head1_idx] && (cls_q[head1_idx] == ClsReg);
    assign st_finish  = rdy && (state_q == StStWait) && st_done;
    // full is taken from the current pointers, so a same-cycle retire cannot make room
    assign alloc_fire = rdy && alloc_valid && !full && !flush_now;

    // Commit decode; class 3 is retired like a control entry
    always_comb begin
        ret_one   = 1'b0;
        ret_two   = 1'b0;
        st_start  = 1'b0;
        flush_now = 1'b0;
        if (rdy && (state_q == StIdle) && head_ok) begin
            if (cls_q[head_idx] == ClsStore) begin
                st_start = 1'b1;
            end else begin
                ret_one = 1'b1;
                if (cls_q[head_idx] == ClsReg) begin
                    ret_two = pair_ok;
                end else begin
                    flush_now = redir_q[head_idx];
                end
            end
        end
    end

    always_comb begin
        ret_cnt = '0;
        if (ret_two) begin
            ret_cnt = (TAG_W+1)'(2);
        end else if (ret_one || st_finish) begin
            ret_cnt = (TAG_W+1)'(1);
        end
    end

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        cls_d   = cls_q;
        size_d  = size_q;
        rd_d    = rd_q;
        data_d  = data_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        head_d  = head_q + ret_cnt;
        tail_d  = tail_q;
        if (rdy && wb0_valid && busy_q[wb0_tag]) begin
            ready_d[wb0_tag] = 1'b1;
            data_d[wb0_tag]  = wb0_data;
            redir_d[wb0_tag] = wb0_redirect;
            pc_d[wb0_tag]    = wb0_pc;
        end
        if (rdy && wb1_valid && busy_q[wb1_tag]) begin
            ready_d[wb1_tag] = 1'b1;
            data_d[wb1_tag]  = wb1_data;
            addr_d[wb1_tag]  = wb1_addr;
        end
        if (ret_one || st_finish) begin
            busy_d[head_idx]  = 1'b0;
            ready_d[head_idx] = 1'b0;
        end
        if (ret_two) begin
            busy_d[head1_idx]  = 1'b0;
            ready_d[head1_idx] = 1'b0;
        end
        if (alloc_fire) begin
            busy_d[tail_idx]  = 1'b1;
            ready_d[tail_idx] = 1'b0;
            redir_d[tail_idx] = 1'b0;
            cls_d[tail_idx]   = alloc_class;
            size_d[tail_idx]  = alloc_size;
            rd_d[tail_idx]    = alloc_rd;
            tail_d            = tail_q + (TAG_W+1)'(1);
        end
        if (flush_now) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Payload is only observed through busy/ready-qualified paths, so it needs no reset
    always_ff @(posedge clk) begin
        cls_q   <= cls_d;
        size_q  <= size_d;
        rd_q    <= rd_d;
        data_q  <= data_d;
        addr_q  <= addr_d;
        pc_q    <= pc_d;
        redir_q <= redir_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (st_start) state_d = StStWait;
            StStWait: if (st_finish) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (flush_now) state_d = StIdle;
    end

    always_comb begin
        st_req_valid = 1'b0;
        st_req_addr  = '0;
        st_req_data  = '0;
        st_req_size  = '0;
        if (state_q == StStWait) begin
            st_req_valid = 1'b1;
            st_req_addr  = addr_q[head_idx];
            st_req_data  = data_q[head_idx];
            st_req_size  = size_q[head_idx];
        end
    end

    always_comb begin
        rs1_ready = 1'b0;
        rs1_data  = '0;
        if (busy_q[rs1_tag] && ready_q[rs1_tag]) begin
            rs1_ready = 1'b1;
            rs1_data  = data_q[rs1_tag];
        end else if (wb1_valid && (wb1_tag == rs1_tag)) begin
            rs1_ready = 1'b1;
            rs1_data  = wb1_data;
        end else if (wb0_valid && (wb0_tag == rs1_tag)) begin
            rs1_ready = 1'b1;
            rs1_data  = wb0_data;
        end
    end

    always_comb begin
        rs2_ready = 1'b0;
        rs2_data  = '0;
        if (busy_q[rs2_tag] && ready_q[rs2_tag]) begin
            rs2_ready = 1'b1;
            rs2_data  = data_q[rs2_tag];
        end else if (wb1_valid && (wb1_tag == rs2_tag)) begin
            rs2_ready = 1'b1;
            rs2_data  = wb1_data;
        end else if (wb0_valid && (wb0_tag == rs2_tag)) begin
            rs2_ready = 1'b1;
            rs2_data  = wb0_data;
        end
    end

    // Pulse outputs are zeroed whenever their valid is low
    always_comb begin
        bc0_valid_d      = rdy && wb0_valid && !flush_now;
        bc0_tag_d        = bc0_valid_d ? wb0_tag : '0;
        bc0_data_d       = bc0_valid_d ? wb0_data : '0;
        bc1_valid_d      = rdy && wb1_valid && !flush_now;
        bc1_tag_d        = bc1_valid_d ? wb1_tag : '0;
        bc1_data_d       = bc1_valid_d ? wb1_data : '0;
        cm0_valid_d      = ret_one;
        cm0_rd_d         = ret_one ? rd_q[head_idx] : '0;
        cm0_data_d       = ret_one ? data_q[head_idx] : '0;
        cm0_tag_d        = ret_one ? head_idx : '0;
        cm1_valid_d      = ret_two;
        cm1_rd_d         = ret_two ? rd_q[head1_idx] : '0;
        cm1_data_d       = ret_two ? data_q[head1_idx] : '0;
        cm1_tag_d        = ret_two ? head1_idx : '0;
        redirect_valid_d = flush_now;
        redirect_pc_d    = flush_now ? pc_q[head_idx] : '0;
        flush_d          = flush_now;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc0_valid_q      <= 1'b0;
            bc0_tag_q        <= '0;
            bc0_data_q       <= '0;
            bc1_valid_q      <= 1'b0;
            bc1_tag_q        <= '0;
            bc1_data_q       <= '0;
            cm0_valid_q      <= 1'b0;
            cm0_rd_q         <= '0;
            cm0_data_q       <= '0;
            cm0_tag_q        <= '0;
            cm1_valid_q      <= 1'b0;
            cm1_rd_q         <= '0;
            cm1_data_q       <= '0;
            cm1_tag_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            bc0_valid_q      <= bc0_valid_d;
            bc0_tag_q        <= bc0_tag_d;
            bc0_data_q       <= bc0_data_d;
            bc1_valid_q      <= bc1_valid_d;
            bc1_tag_q        <= bc1_tag_d;
            bc1_data_q       <= bc1_data_d;
            cm0_valid_q      <= cm0_valid_d;
            cm0_rd_q         <= cm0_rd_d;
            cm0_data_q       <= cm0_data_d;
            cm0_tag_q        <= cm0_tag_d;
            cm1_valid_q      <= cm1_valid_d;
            cm1_rd_q         <= cm1_rd_d;
            cm1_data_q       <= cm1_data_d;
            cm1_tag_q        <= cm1_tag_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign bc0_valid      = bc0_valid_q;
    assign bc0_tag        = bc0_tag_q;
    assign bc0_data       = bc0_data_q;
    assign bc1_valid      = bc1_valid_q;
    assign bc1_tag        = bc1_tag_q;
    assign bc1_data       = bc1_data_q;
    assign cm0_valid      = cm0_valid_q;
    assign cm0_rd         = cm0_rd_q;
    assign cm0_data       = cm0_data_q;
    assign cm0_tag        = cm0_tag_q;
    assign cm1_valid      = cm1_valid_q;
    assign cm1_rd         = cm1_rd_q;
    assign cm1_data       = cm1_data_q;
    assign cm1_tag        = cm1_tag_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

endmodule

// File: tb/tb_re_order_buffer_p.sv
// Bench for re_order_buffer_p at DEPTH=4: a per-cycle vector table plus hand-written store,
// redirect, stall and reset sequences; commits are checked against an in-order scoreboard.
module tb_re_order_buffer_p;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
    logic              alloc_valid = 1'b0;
    logic [1:0]        alloc_class = '0;
    logic [1:0]        alloc_size = '0;
    logic [4:0]        alloc_rd = '0;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  rs1_tag = '0;
    logic              rs1_ready;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs2_tag = '0;
    logic              rs2_ready;
    logic [DATA_W-1:0] rs2_data;
    logic              wb0_valid = 1'b0;
    logic [TAG_W-1:0]  wb0_tag = '0;
    logic [DATA_W-1:0] wb0_data = '0;
    logic              wb0_redirect = 1'b0;
    logic [DATA_W-1:0] wb0_pc = '0;
    logic              wb1_valid = 1'b0;
    logic [TAG_W-1:0]  wb1_tag = '0;
    logic [DATA_W-1:0] wb1_data = '0;
    logic [DATA_W-1:0] wb1_addr = '0;
    logic              bc0_valid, bc1_valid;
    logic [TAG_W-1:0]  bc0_tag, bc1_tag;
    logic [DATA_W-1:0] bc0_data, bc1_data;
    logic              cm0_valid, cm1_valid;
    logic [4:0]        cm0_rd, cm1_rd;
    logic [DATA_W-1:0] cm0_data, cm1_data;
    logic [TAG_W-1:0]  cm0_tag, cm1_tag;
    logic              st_req_valid;
    logic [DATA_W-1:0] st_req_addr, st_req_data;
    logic [1:0]        st_req_size;
    logic              st_done = 1'b0;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              flush;
    logic [TAG_W:0]    occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } cm_t;
    cm_t sb[$];

    typedef struct {
        logic        av;
        logic [1:0]  acls;
        logic [4:0]  ard;
        logic [31:0] cdata;
        logic        w0v;
        logic [1:0]  w0t;
        logic [31:0] w0d;
        logic        w1v;
        logic [1:0]  w1t;
        logic [31:0] w1d;
        logic [1:0]  r1t;
        logic [1:0]  r2t;
        logic        e_ardy;
        logic [1:0]  e_atag;
        logic [2:0]  e_occ;
        logic        e_r1r;
        logic [31:0] e_r1d;
        logic        e_r2r;
        logic [31:0] e_r2d;
        logic        e_bc0;
        logic        e_bc1;
        logic        e_cm0;
        logic        e_cm1;
    } vec_t;
    localparam int NV = 11;
    vec_t tbl [NV];

    re_order_buffer_p #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_class(alloc_class), .alloc_size(alloc_size),
        .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .rs1_tag(rs1_tag), .rs1_ready(rs1_ready), .rs1_data(rs1_data),
        .rs2_tag(rs2_tag), .rs2_ready(rs2_ready), .rs2_data(rs2_data),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb0_redirect(wb0_redirect), .wb0_pc(wb0_pc),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data), .wb1_addr(wb1_addr),
        .bc0_valid(bc0_valid), .bc0_tag(bc0_tag), .bc0_data(bc0_data),
        .bc1_valid(bc1_valid), .bc1_tag(bc1_tag), .bc1_data(bc1_data),
        .cm0_valid(cm0_valid), .cm0_rd(cm0_rd), .cm0_data(cm0_data), .cm0_tag(cm0_tag),
        .cm1_valid(cm1_valid), .cm1_rd(cm1_rd), .cm1_data(cm1_data), .cm1_tag(cm1_tag),
        .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .st_req_size(st_req_size), .st_done(st_done),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cm(input string nm, input logic [1:0] t, input logic [4:0] r,
                          input logic [31:0] d);
        cm_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected commit: tag %0d rd %0d data %0h", nm, t, r, d);
        end else begin
            e = sb.pop_front();
            if (t !== e.tag || r !== e.rd || d !== e.data) begin
                errors++;
                $display("FAIL %s: got tag %0d rd %0d data %0h, expected tag %0d rd %0d data %0h",
                         nm, t, r, d, e.tag, e.rd, e.data);
            end
        end
    endtask

    // Commit monitor: every cm pulse must match the oldest outstanding instruction
    always @(negedge clk) begin
        if (rst) begin
            if (cm0_valid) chk_cm("cm0", cm0_tag, cm0_rd, cm0_data);
            if (cm1_valid) chk_cm("cm1", cm1_tag, cm1_rd, cm1_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_off;
        wb0_valid    = 1'b0;
        wb0_redirect = 1'b0;
        wb1_valid    = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 1, 'h11, 0, 0, 0,     0, 0, 0,     0, 1, 1, 0, 0,
                    0, 0,     0, 0,     0, 0, 0, 0};
        tbl[1]  = '{1, 0, 2, 'h22, 0, 0, 0,     0, 0, 0,     0, 1, 1, 1, 1,
                    0, 0,     0, 0,     0, 0, 0, 0};
        tbl[2]  = '{1, 0, 3, 'h55, 0, 0, 0,     0, 0, 0,     0, 1, 1, 2, 2,
                    0, 0,     0, 0,     0, 0, 0, 0};
        tbl[3]  = '{1, 0, 4, 'h44, 0, 0, 0,     0, 0, 0,     0, 1, 1, 3, 3,
                    0, 0,     0, 0,     0, 0, 0, 0};
        tbl[4]  = '{1, 0, 5, 'h00, 0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 4,
                    0, 0,     0, 0,     0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 'h00, 1, 3, 'h44,  1, 2, 'h55,  2, 3, 0, 0, 4,
                    1, 'h55,  1, 'h44,  0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 'h00, 0, 0, 0,     0, 0, 0,     2, 0, 0, 0, 4,
                    1, 'h55,  0, 0,     1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 'h00, 1, 0, 'h11,  1, 1, 'h22,  1, 0, 0, 0, 4,
                    1, 'h22,  1, 'h11,  0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 'h00, 0, 0, 0,     0, 0, 0,     0, 3, 0, 0, 4,
                    1, 'h11,  1, 'h44,  1, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 'h00, 0, 0, 0,     0, 0, 0,     3, 0, 1, 0, 2,
                    1, 'h44,  0, 0,     0, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 'h00, 0, 0, 0,     0, 0, 0,     2, 3, 1, 0, 0,
                    0, 0,     0, 0,     0, 0, 1, 1};

        // Reset values while rst is held low
        #10;
        chk("rst occupancy", occupancy, 0);
        chk("rst bc0_valid", bc0_valid, 0);
        chk("rst cm0_valid", cm0_valid, 0);
        chk("rst st_req_valid", st_req_valid, 0);
        chk("rst redirect_valid", redirect_valid, 0);
        chk("rst flush", flush, 0);
        #2 rst = 1'b1;
        tick;
        chk("post-rst alloc_ready", alloc_ready, 1);
        chk("post-rst alloc_tag", alloc_tag, 0);

        // Fill to full, ignored 5th alloc, forwarding, dual writeback and dual commit
        for (int i = 0; i < NV; i++) begin
            alloc_valid = tbl[i].av;
            alloc_class = tbl[i].acls;
            alloc_size  = 2'd0;
            alloc_rd    = tbl[i].ard;
            wb0_valid   = tbl[i].w0v;
            wb0_tag     = tbl[i].w0t;
            wb0_data    = tbl[i].w0d;
            wb1_valid   = tbl[i].w1v;
            wb1_tag     = tbl[i].w1t;
            wb1_data    = tbl[i].w1d;
            rs1_tag     = tbl[i].r1t;
            rs2_tag     = tbl[i].r2t;
            if (tbl[i].av && tbl[i].e_ardy) sb.push_back('{tbl[i].e_atag, tbl[i].ard, tbl[i].cdata});
            @(negedge clk);
            chk($sformatf("v%0d alloc_ready", i), alloc_ready, tbl[i].e_ardy);
            chk($sformatf("v%0d alloc_tag", i), alloc_tag, tbl[i].e_atag);
            chk($sformatf("v%0d occupancy", i), occupancy, tbl[i].e_occ);
            chk($sformatf("v%0d rs1_ready", i), rs1_ready, tbl[i].e_r1r);
            chk($sformatf("v%0d rs1_data", i), rs1_data, tbl[i].e_r1d);
            chk($sformatf("v%0d rs2_ready", i), rs2_ready, tbl[i].e_r2r);
            chk($sformatf("v%0d rs2_data", i), rs2_data, tbl[i].e_r2d);
            chk($sformatf("v%0d bc0_valid", i), bc0_valid, tbl[i].e_bc0);
            chk($sformatf("v%0d bc1_valid", i), bc1_valid, tbl[i].e_bc1);
            chk($sformatf("v%0d cm0_valid", i), cm0_valid, tbl[i].e_cm0);
            chk($sformatf("v%0d cm1_valid", i), cm1_valid, tbl[i].e_cm1);
            tick;
        end
        alloc_valid = 1'b0;
        wb_off();

        // Store at head blocks commit until st_done
        alloc_valid = 1'b1; alloc_class = 2'd1; alloc_size = 2'd0; alloc_rd = 5'd0;
        tick;
        alloc_class = 2'd0; alloc_rd = 5'd7;
        sb.push_back('{2'd1, 5'd7, 32'h77});
        tick;
        alloc_valid = 1'b0;
        wb1_valid = 1'b1; wb1_tag = 2'd0; wb1_data = 32'hAB; wb1_addr = 32'h1000;
        wb0_valid = 1'b1; wb0_tag = 2'd1; wb0_data = 32'h77; wb0_pc = '0;
        tick;
        wb_off();
        tick;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("st%0d st_req_valid", k), st_req_valid, 1);
            chk($sformatf("st%0d st_req_addr", k), st_req_addr, 32'h1000);
            chk($sformatf("st%0d st_req_data", k), st_req_data, 32'hAB);
            chk($sformatf("st%0d st_req_size", k), st_req_size, 0);
            chk($sformatf("st%0d cm0_valid", k), cm0_valid, 0);
            chk($sformatf("st%0d occupancy", k), occupancy, 2);
            if (k == 2) st_done = 1'b1;
            tick;
        end
        st_done = 1'b0;
        chk("st done st_req_valid", st_req_valid, 0);
        chk("st done occupancy", occupancy, 1);
        tick;
        chk("st after commit occupancy", occupancy, 0);

        // Mispredicted control at head with two younger entries
        alloc_valid = 1'b1; alloc_class = 2'd2; alloc_rd = 5'd9;
        sb.push_back('{2'd2, 5'd9, 32'h99});
        tick;
        alloc_class = 2'd0; alloc_rd = 5'd10;
        tick;
        alloc_rd = 5'd11;
        tick;
        alloc_valid = 1'b0;
        wb0_valid = 1'b1; wb0_tag = 2'd2; wb0_data = 32'h99; wb0_redirect = 1'b1;
        wb0_pc = 32'h200;
        wb1_valid = 1'b1; wb1_tag = 2'd3; wb1_data = 32'h33; wb1_addr = '0;
        tick;
        chk("redir pre occupancy", occupancy, 3);
        alloc_valid = 1'b1; alloc_rd = 5'd12;
        wb1_valid = 1'b0;
        wb0_tag = 2'd0; wb0_data = 32'h12; wb0_redirect = 1'b0; wb0_pc = '0;
        tick;
        alloc_valid = 1'b0;
        wb_off();
        chk("redir redirect_valid", redirect_valid, 1);
        chk("redir redirect_pc", redirect_pc, 32'h200);
        chk("redir flush", flush, 1);
        chk("redir occupancy", occupancy, 0);
        chk("redir alloc_tag", alloc_tag, 0);
        chk("redir bc0_valid", bc0_valid, 0);
        tick;
        chk("redir end redirect_valid", redirect_valid, 0);
        chk("redir end flush", flush, 0);
        chk("redir end occupancy", occupancy, 0);

        // rdy low freezes the buffer despite alloc and writeback activity
        alloc_valid = 1'b1; alloc_class = 2'd0; alloc_rd = 5'd13;
        sb.push_back('{2'd0, 5'd13, 32'hCC});
        tick;
        rdy = 1'b0;
        alloc_rd = 5'd14;
        wb0_valid = 1'b1; wb0_tag = 2'd0; wb0_data = 32'hDD;
        wb1_valid = 1'b1; wb1_tag = 2'd0; wb1_data = 32'hEE;
        rs1_tag = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("stall%0d occupancy", k), occupancy, 1);
            chk($sformatf("stall%0d alloc_tag", k), alloc_tag, 1);
            chk($sformatf("stall%0d bc0_valid", k), bc0_valid, 0);
            chk($sformatf("stall%0d bc1_valid", k), bc1_valid, 0);
            chk($sformatf("stall%0d cm0_valid", k), cm0_valid, 0);
            if (k == 0) chk("stall rs1 wb1 priority", rs1_data, 32'hEE);
        end
        rdy = 1'b1;
        alloc_valid = 1'b0;
        wb1_valid = 1'b0;
        wb0_data = 32'hCC;
        tick;
        wb_off();
        chk("resume bc0_valid", bc0_valid, 1);
        chk("resume bc0_tag", bc0_tag, 0);
        chk("resume bc0_data", bc0_data, 32'hCC);
        chk("resume bc1_valid", bc1_valid, 0);
        tick;
        chk("resume occupancy", occupancy, 0);
        tick;
        chk("scoreboard drained", sb.size(), 0);

        // Reset asserted mid-store drops the request at once
        alloc_valid = 1'b1; alloc_class = 2'd1; alloc_size = 2'd2; alloc_rd = 5'd0;
        tick;
        alloc_valid = 1'b0;
        wb1_valid = 1'b1; wb1_tag = 2'd1; wb1_data = 32'h5A; wb1_addr = 32'h2000;
        tick;
        wb_off();
        tick;
        chk("rst-st st_req_valid", st_req_valid, 1);
        chk("rst-st st_req_size", st_req_size, 2);
        #2 rst = 1'b0;
        #1;
        chk("rst-st async drop", st_req_valid, 0);
        chk("rst-st occupancy", occupancy, 0);
        rst = 1'b1;
        tick;
        chk("rst-st stays idle", st_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
